// File: rtl/branch_retire_tracker_if.sv
// -----------------------------------------------------------------------------
// branch_retire_tracker_if
// Bundles the fetch / execute / ROB side of the branch retire tracker with the
// predictor update (rt_*) bus it produces.
//   master : the pipeline side (drives fetch alloc, execute resolve, ROB retire,
//            enable) and observes the tracker status and update bus.
//   slave  : the tracker itself.
// Signals:
//   enable                 global accept gate
//   fe_* / fe_alloc_ready / fe_alloc_tag     fetch-time allocation handshake
//   ex_*                   execute-stage resolution
//   rob_retire_branch / retire_ready         in-order retire handshake
//   rt_* / flush           one-cycle predictor update pulse and mispredict flush
//   count                  occupied entries
// -----------------------------------------------------------------------------
interface branch_retire_tracker_if #(
    parameter int BRQ_SIZE  = 8,
    parameter int OBQ_IDX_W = 5
);
    localparam int TAG_W = $clog2(BRQ_SIZE);
    localparam int CNT_W = TAG_W + 1;

    logic                 enable;
    logic                 fe_alloc_valid;
    logic                 fe_cond_branch;
    logic                 fe_direct_branch;
    logic [31:0]          fe_pc;
    logic                 fe_pred_taken;
    logic [31:0]          fe_pred_pc;
    logic [OBQ_IDX_W-1:0] fe_obq_index;
    logic                 fe_alloc_ready;
    logic [TAG_W-1:0]     fe_alloc_tag;
    logic                 ex_valid;
    logic [TAG_W-1:0]     ex_tag;
    logic                 ex_taken;
    logic [31:0]          ex_target;
    logic                 rob_retire_branch;
    logic                 retire_ready;
    logic                 rt_en_branch;
    logic                 rt_cond_branch;
    logic                 rt_direct_branch;
    logic                 rt_branch_taken;
    logic                 rt_prediction_correct;
    logic [31:0]          rt_pc;
    logic [31:0]          rt_calculated_pc;
    logic [OBQ_IDX_W-1:0] rt_branch_index;
    logic                 flush;
    logic [CNT_W-1:0]     count;

    modport master (
        output enable, fe_alloc_valid, fe_cond_branch, fe_direct_branch, fe_pc,
               fe_pred_taken, fe_pred_pc, fe_obq_index, ex_valid, ex_tag,
               ex_taken, ex_target, rob_retire_branch,
        input  fe_alloc_ready, fe_alloc_tag, retire_ready, rt_en_branch,
               rt_cond_branch, rt_direct_branch, rt_branch_taken,
               rt_prediction_correct, rt_pc, rt_calculated_pc, rt_branch_index,
               flush, count
    );

    modport slave (
        input  enable, fe_alloc_valid, fe_cond_branch, fe_direct_branch, fe_pc,
               fe_pred_taken, fe_pred_pc, fe_obq_index, ex_valid, ex_tag,
               ex_taken, ex_target, rob_retire_branch,
        output fe_alloc_ready, fe_alloc_tag, retire_ready, rt_en_branch,
               rt_cond_branch, rt_direct_branch, rt_branch_taken,
               rt_prediction_correct, rt_pc, rt_calculated_pc, rt_branch_index,
               flush, count
    );
endinterface

// File: rtl/branch_retire_tracker.sv
// -----------------------------------------------------------------------------
// branch_retire_tracker
// Circular queue of in-flight predicted branches. Fetch allocates at the tail,
// execute records the actual outcome per entry, and the ROB retires the head
// in order. Each retire produces a one-cycle registered update on the rt_* bus
// for the predictor; a wrong prediction also raises flush and empties the
// whole queue, since every younger entry belongs to the squashed path.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   bus    branch_retire_tracker_if.slave (fetch/execute/ROB/update signals)
// -----------------------------------------------------------------------------
module branch_retire_tracker #(
    parameter int BRQ_SIZE  = 8,
    parameter int OBQ_SIZE  = 16,
    parameter int OBQ_IDX_W = $clog2(OBQ_SIZE) + 1
) (
    input logic                     clock,
    input logic                     reset,
    branch_retire_tracker_if.slave  bus
);
    localparam int TAG_W = $clog2(BRQ_SIZE);
    localparam int CNT_W = TAG_W + 1;

    typedef struct packed {
        logic                 cond;
        logic                 direct;
        logic [31:0]          pc;
        logic                 pred_taken;
        logic [31:0]          pred_pc;
        logic [OBQ_IDX_W-1:0] obq_index;
        logic                 ex_taken;
        logic [31:0]          ex_target;
    } entry_t;

    // Prediction is right only if the direction matches and, when taken,
    // the target matches too (a not-taken target is irrelevant).
    function automatic logic pred_correct(input entry_t e);
        return (e.ex_taken == e.pred_taken) &&
               (!e.ex_taken || (e.ex_target == e.pred_pc));
    endfunction

    // Architectural next PC of the branch.
    function automatic logic [31:0] calc_pc(input entry_t e);
        return e.ex_taken ? e.ex_target : (e.pc + 32'd4);
    endfunction

    entry_t               entry_q [BRQ_SIZE];
    logic [BRQ_SIZE-1:0]  valid_q;
    logic [BRQ_SIZE-1:0]  resolved_q;
    logic [TAG_W-1:0]     head_q;
    logic [TAG_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;

    logic                 rt_en_q;
    logic                 rt_cond_q;
    logic                 rt_direct_q;
    logic                 rt_taken_q;
    logic                 rt_correct_q;
    logic [31:0]          rt_pc_q;
    logic [31:0]          rt_calc_pc_q;
    logic [OBQ_IDX_W-1:0] rt_index_q;
    logic                 flush_q;

    entry_t               head_e_s;
    logic                 alloc_ready_s;
    logic                 retire_ready_s;
    logic                 alloc_fire_s;
    logic                 resolve_fire_s;
    logic                 retire_fire_s;
    logic                 mispredict_s;
    logic                 head_correct_s;
    logic [CNT_W-1:0]     count_d;

    // Accept conditions; retire_ready looks only at registered state so a
    // same-cycle resolve of the head is never bypassed into a retire.
    always_comb begin
        head_e_s       = entry_q[head_q];
        alloc_ready_s  = !reset && (count_q < CNT_W'(BRQ_SIZE));
        retire_ready_s = valid_q[head_q] && resolved_q[head_q];
        alloc_fire_s   = bus.enable && bus.fe_alloc_valid && alloc_ready_s;
        resolve_fire_s = bus.enable && bus.ex_valid &&
                         valid_q[bus.ex_tag] && !resolved_q[bus.ex_tag];
        retire_fire_s  = bus.enable && bus.rob_retire_branch && retire_ready_s;
        head_correct_s = pred_correct(head_e_s);
        mispredict_s   = retire_fire_s && !head_correct_s;
        count_d        = count_q + CNT_W'(alloc_fire_s) - CNT_W'(retire_fire_s);
    end

    // Entry payload; occupancy is tracked by valid/resolved so no reset here.
    // A flush drops any same-cycle alloc or resolve.
    always_ff @(posedge clock) begin
        if (!reset && !mispredict_s) begin
            if (alloc_fire_s) begin
                entry_q[tail_q] <= '{cond:       bus.fe_cond_branch,
                                     direct:     bus.fe_direct_branch,
                                     pc:         bus.fe_pc,
                                     pred_taken: bus.fe_pred_taken,
                                     pred_pc:    bus.fe_pred_pc,
                                     obq_index:  bus.fe_obq_index,
                                     ex_taken:   1'b0,
                                     ex_target:  32'd0};
            end
            // Tail slot is always invalid, so it never collides with a resolve.
            if (resolve_fire_s) begin
                entry_q[bus.ex_tag].ex_taken  <= bus.ex_taken;
                entry_q[bus.ex_tag].ex_target <= bus.ex_target;
            end
        end
    end

    // Queue control state and the registered predictor update bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= {BRQ_SIZE{1'b0}};
            resolved_q   <= {BRQ_SIZE{1'b0}};
            head_q       <= {TAG_W{1'b0}};
            tail_q       <= {TAG_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            rt_en_q      <= 1'b0;
            rt_cond_q    <= 1'b0;
            rt_direct_q  <= 1'b0;
            rt_taken_q   <= 1'b0;
            rt_correct_q <= 1'b0;
            rt_pc_q      <= 32'd0;
            rt_calc_pc_q <= 32'd0;
            rt_index_q   <= {OBQ_IDX_W{1'b0}};
            flush_q      <= 1'b0;
        end else begin
            rt_en_q <= retire_fire_s;
            flush_q <= mispredict_s;
            // Data fields hold their value between pulses.
            if (retire_fire_s) begin
                rt_cond_q    <= head_e_s.cond;
                rt_direct_q  <= head_e_s.direct;
                rt_taken_q   <= head_e_s.ex_taken;
                rt_correct_q <= head_correct_s;
                rt_pc_q      <= head_e_s.pc;
                rt_calc_pc_q <= calc_pc(head_e_s);
                rt_index_q   <= head_e_s.obq_index;
            end

            if (mispredict_s) begin
                valid_q    <= {BRQ_SIZE{1'b0}};
                resolved_q <= {BRQ_SIZE{1'b0}};
                head_q     <= {TAG_W{1'b0}};
                tail_q     <= {TAG_W{1'b0}};
                count_q    <= {CNT_W{1'b0}};
            end else begin
                if (resolve_fire_s) begin
                    resolved_q[bus.ex_tag] <= 1'b1;
                end
                // Alloc (tail) and retire (head) never hit the same slot:
                // alloc needs a non-full queue, retire a non-empty one.
                if (alloc_fire_s) begin
                    valid_q[tail_q]    <= 1'b1;
                    resolved_q[tail_q] <= 1'b0;
                    tail_q             <= tail_q + TAG_W'(1);
                end
                if (retire_fire_s) begin
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + TAG_W'(1);
                end
                count_q <= count_d;
            end
        end
    end

    assign bus.fe_alloc_ready        = alloc_ready_s;
    assign bus.fe_alloc_tag          = reset ? {TAG_W{1'b0}} : tail_q;
    assign bus.retire_ready          = retire_ready_s;
    assign bus.count                 = count_q;
    assign bus.rt_en_branch          = rt_en_q;
    assign bus.rt_cond_branch        = rt_cond_q;
    assign bus.rt_direct_branch      = rt_direct_q;
    assign bus.rt_branch_taken       = rt_taken_q;
    assign bus.rt_prediction_correct = rt_correct_q;
    assign bus.rt_pc                 = rt_pc_q;
    assign bus.rt_calculated_pc      = rt_calc_pc_q;
    assign bus.rt_branch_index       = rt_index_q;
    assign bus.flush                 = flush_q;
endmodule

// File: tb/tb_branch_retire_tracker.sv
// -----------------------------------------------------------------------------
// tb_branch_retire_tracker
// Drives the tracker through its interface with a reference queue model.
// Expected update-bus records are pushed to a scoreboard when a retire is
// driven and popped when the DUT raises rt_en_branch.
// -----------------------------------------------------------------------------
module tb_branch_retire_tracker;
    localparam int N  = 8;
    localparam int OW = 5;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    branch_retire_tracker_if #(.BRQ_SIZE(N), .OBQ_IDX_W(OW)) bus ();

    branch_retire_tracker #(.BRQ_SIZE(N), .OBQ_SIZE(16), .OBQ_IDX_W(OW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   calc;
        logic          taken;
        logic          correct;
        logic          cond;
        logic          direct;
        logic [OW-1:0] idx;
    } exp_t;

    exp_t sb[$];

    // reference queue model
    bit            m_valid [N];
    bit            m_res   [N];
    bit            m_pt    [N];
    bit            m_tk    [N];
    bit            m_cond  [N];
    bit            m_dir   [N];
    logic [31:0]   m_pc    [N];
    logic [31:0]   m_ppc   [N];
    logic [31:0]   m_tgt   [N];
    logic [OW-1:0] m_idx   [N];
    int            m_head, m_tail, m_count;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_res[i]   = 1'b0;
        end
        m_head = 0; m_tail = 0; m_count = 0;
    endtask

    task automatic idle_inputs();
        bus.fe_alloc_valid    = 1'b0;
        bus.ex_valid          = 1'b0;
        bus.rob_retire_branch = 1'b0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input bit pt, input logic [31:0] ppc,
                             input logic [OW-1:0] idx, input bit cond = 1'b1, input bit dir = 1'b1);
        bus.fe_alloc_valid   = 1'b1;
        bus.fe_pc            = pc;
        bus.fe_pred_taken    = pt;
        bus.fe_pred_pc       = ppc;
        bus.fe_obq_index     = idx;
        bus.fe_cond_branch   = cond;
        bus.fe_direct_branch = dir;
    endtask

    task automatic set_res(input int tag, input bit tk, input logic [31:0] tgt);
        bus.ex_valid  = 1'b1;
        bus.ex_tag    = 3'(tag);
        bus.ex_taken  = tk;
        bus.ex_target = tgt;
    endtask

    task automatic set_ret();
        bus.rob_retire_branch = 1'b1;
    endtask

    // One clock with whatever inputs are currently driven: predict, clock, compare.
    task automatic apply();
        bit   exp_rdy, rr, af, rf, tf, mis;
        int   h, t;
        exp_t e, g;
        exp_rdy = (m_count < N);
        rr      = m_valid[m_head] && m_res[m_head];
        check_eq("alloc_ready", bus.fe_alloc_ready, exp_rdy);
        check_eq("retire_ready", bus.retire_ready, rr);
        if (bus.fe_alloc_valid) check_eq("alloc_tag", bus.fe_alloc_tag, m_tail);
        t   = int'(bus.ex_tag);
        af  = bus.enable && bus.fe_alloc_valid && exp_rdy;
        rf  = bus.enable && bus.ex_valid && m_valid[t] && !m_res[t];
        tf  = bus.enable && bus.rob_retire_branch && rr;
        mis = 1'b0;
        if (tf) begin
            h         = m_head;
            e.pc      = m_pc[h];
            e.taken   = m_tk[h];
            e.calc    = m_tk[h] ? m_tgt[h] : m_pc[h] + 32'd4;
            e.correct = (m_tk[h] == m_pt[h]) && (!m_tk[h] || m_tgt[h] == m_ppc[h]);
            e.cond    = m_cond[h];
            e.direct  = m_dir[h];
            e.idx     = m_idx[h];
            sb.push_back(e);
            mis = !e.correct;
        end
        @(posedge clock);
        #1;
        if (mis) begin
            model_clear();
        end else begin
            if (rf) begin
                m_res[t] = 1'b1;
                m_tk[t]  = bus.ex_taken;
                m_tgt[t] = bus.ex_target;
            end
            if (af) begin
                m_valid[m_tail] = 1'b1;
                m_res[m_tail]   = 1'b0;
                m_pc[m_tail]    = bus.fe_pc;
                m_pt[m_tail]    = bus.fe_pred_taken;
                m_ppc[m_tail]   = bus.fe_pred_pc;
                m_idx[m_tail]   = bus.fe_obq_index;
                m_cond[m_tail]  = bus.fe_cond_branch;
                m_dir[m_tail]   = bus.fe_direct_branch;
                m_tail          = (m_tail + 1) % N;
                m_count++;
            end
            if (tf) begin
                m_valid[m_head] = 1'b0;
                m_head          = (m_head + 1) % N;
                m_count--;
            end
        end
        check_eq("rt_en", bus.rt_en_branch, tf);
        check_eq("flush", bus.flush, mis);
        if (bus.rt_en_branch && sb.size() > 0) begin
            g = sb.pop_front();
            check_eq("rt_pc", bus.rt_pc, g.pc);
            check_eq("rt_calc_pc", bus.rt_calculated_pc, g.calc);
            check_eq("rt_taken", bus.rt_branch_taken, g.taken);
            check_eq("rt_correct", bus.rt_prediction_correct, g.correct);
            check_eq("rt_cond", bus.rt_cond_branch, g.cond);
            check_eq("rt_direct", bus.rt_direct_branch, g.direct);
            check_eq("rt_index", bus.rt_branch_index, g.idx);
        end
        check_eq("count", bus.count, m_count);
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clock);
        #1;
        check_eq("rst_alloc_ready", bus.fe_alloc_ready, 1'b0);
        check_eq("rst_alloc_tag", bus.fe_alloc_tag, 0);
        check_eq("rst_count", bus.count, 0);
        check_eq("rst_rt_en", bus.rt_en_branch, 1'b0);
        check_eq("rst_flush", bus.flush, 1'b0);
        check_eq("rst_retire_ready", bus.retire_ready, 1'b0);
        reset = 1'b0;
        model_clear();
        #1;
        check_eq("post_rst_alloc_ready", bus.fe_alloc_ready, 1'b1);
    endtask

    initial begin
        int t;
        bus.enable           = 1'b1;
        bus.fe_pc            = 32'd0;
        bus.fe_pred_taken    = 1'b0;
        bus.fe_pred_pc       = 32'd0;
        bus.fe_obq_index     = '0;
        bus.fe_cond_branch   = 1'b0;
        bus.fe_direct_branch = 1'b0;
        bus.ex_tag           = '0;
        bus.ex_taken         = 1'b0;
        bus.ex_target        = 32'd0;
        idle_inputs();

        // 1. reset
        do_reset();

        // 2. mispredict: not-taken predicted, actually taken to 160
        set_alloc(32'd80, 1'b0, 32'd84, 5'd3); apply();
        set_res(0, 1'b1, 32'd160); apply();
        set_ret(); apply();

        // 3. correct taken prediction; a second resolve is ignored
        t = m_tail;
        set_alloc(32'h20, 1'b1, 32'h30, 5'd5, 1'b1, 1'b0); apply();
        set_res(t, 1'b1, 32'h30); apply();
        set_res(t, 1'b0, 32'h44); apply();
        set_ret(); apply();

        // 4. stall on unresolved head, enable-low cycle, then wrong target
        t = m_tail;
        set_alloc(32'h40, 1'b1, 32'h100, 5'd7, 1'b0, 1'b1); apply();
        for (int i = 0; i < 3; i++) begin
            set_ret(); apply();
        end
        bus.enable = 1'b0;
        set_res(t, 1'b1, 32'h200); set_ret(); set_alloc(32'h50, 1'b0, 32'h0, 5'd1); apply();
        bus.enable = 1'b1;
        set_res(t, 1'b1, 32'h200); apply();
        set_ret(); apply();

        // 5. fill, overflow attempt, retire/alloc wrap-around
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_alloc(32'h1000 + 32'(i * 16), i[0], 32'h1080 + 32'(i * 16), 5'(i)); apply();
        end
        set_alloc(32'h1F00, 1'b0, 32'h0, 5'd31); apply();
        for (int i = 0; i < N; i++) begin
            set_res(i, m_pt[i], m_ppc[i]); apply();
        end
        set_alloc(32'h2000, 1'b1, 32'h2100, 5'd10); set_ret(); apply();
        for (int i = 0; i < 2; i++) begin
            set_alloc(32'h2000 + 32'(i * 8), 1'b1, 32'h2100, 5'(10 + i)); set_ret(); apply();
        end
        set_alloc(32'h2010, 1'b0, 32'h0, 5'd12); apply();
        for (int i = 0; i < 3; i++) begin
            set_res(i, m_pt[i], m_ppc[i]); apply();
        end
        for (int i = 0; i < 2 * N && m_count > 0; i++) begin
            set_ret(); apply();
        end

        // 6. mispredict flush drops same-cycle alloc and younger entries
        t = m_tail;
        set_alloc(32'h3000, 1'b0, 32'h0, 5'd2); apply();
        set_alloc(32'h3010, 1'b1, 32'h3100, 5'd4); apply();
        set_alloc(32'h3020, 1'b0, 32'h0, 5'd6); apply();
        set_res(t, 1'b1, 32'h3800); apply();
        set_res((t + 1) % N, 1'b1, 32'h3100); apply();
        set_alloc(32'h3030, 1'b0, 32'h0, 5'd8); set_ret(); apply();
        for (int i = 0; i < 2; i++) begin
            set_ret(); apply();
        end

        check_eq("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/branch_retire_tracker.md
Name: branch_retire_tracker

Overview:
- Retire-side writer for the branch predictor's update interface.
- At fetch, records every predicted branch (pc, prediction, predicted target, OBQ index) in a circular queue; captures the execute-stage outcome per entry.
- On in-order retire, drives the predictor's rt_* update bus for one cycle and signals pipeline flush on misprediction.
- Sits between fetch/execute/ROB and the BP module.

Parameters:
- BRQ_SIZE, 8, queue entries (power of two, ≥2).
- OBQ_IDX_W, $clog2(`OBQ_SIZE)+1, width of the predictor OBQ index carried per entry.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  gates all state updates; when low, no alloc/resolve/retire is accepted.
- fe_alloc_valid  in  1  fetch allocates a branch entry this cycle.
- fe_cond_branch  in  1  branch is conditional.
- fe_direct_branch  in  1  branch is direct.
- fe_pc  in  32  branch PC.
- fe_pred_taken  in  1  predictor's taken prediction.
- fe_pred_pc  in  32  predicted target.
- fe_obq_index  in  OBQ_IDX_W  predictor OBQ index (next_pc_index).
- fe_alloc_ready  out  1  queue not full; combinational.
- fe_alloc_tag  out  $clog2(BRQ_SIZE)  tail slot tag given to the allocating branch.
- ex_valid  in  1  execute resolves a branch.
- ex_tag  in  $clog2(BRQ_SIZE)  entry being resolved.
- ex_taken  in  1  actual direction.
- ex_target  in  32  actual taken target.
- rob_retire_branch  in  1  ROB retires the oldest branch.
- retire_ready  out  1  head valid and resolved; combinational.
- rt_en_branch  out  1  update-bus valid pulse (registered).
- rt_cond_branch, rt_direct_branch, rt_branch_taken, rt_prediction_correct  out  1 each  update fields.
- rt_pc, rt_calculated_pc  out  32  update fields.
- rt_branch_index  out  OBQ_IDX_W  update field.
- flush  out  1  mispredict flush pulse, coincident with rt_en_branch.
- count  out  $clog2(BRQ_SIZE)+1  occupied entries.

Behaviour:
- **Storage:** head/tail pointers of $clog2(BRQ_SIZE) bits; both wrap modulo BRQ_SIZE. count ranges 0..BRQ_SIZE. Each entry holds valid, resolved, all fe_* fields, ex_taken and ex_target.
- **Reset:**
  - head, tail, count and all valid/resolved bits are 0.
  - All rt_* outputs and flush are 0.
  - fe_alloc_ready is 0 while reset is high; fe_alloc_tag is 0.
- **Allocate:** accepted at a posedge when enable & fe_alloc_valid & fe_alloc_ready, where fe_alloc_ready = !reset & (count < BRQ_SIZE). The entry is written at tail, valid=1, resolved=0, and tail increments.
- **Resolve:** accepted when enable & ex_valid & entry[ex_tag].valid & !entry[ex_tag].resolved. It stores ex_taken/ex_target and sets resolved. Any resolve to an invalid or already-resolved entry is ignored.
- **Retire:**
  - Accepted when enable & rob_retire_branch & retire_ready. retire_ready reads registered state only; a same-cycle resolve of the head is not bypassed.
  - Head is popped: valid cleared, head increments.
  - Next cycle, for exactly 1 cycle:
    - rt_en_branch = 1; cond/direct/pc/branch_index are copied from the entry.
    - rt_branch_taken = ex_taken.
    - rt_calculated_pc = ex_taken ? ex_target : pc+4 (32-bit wrap).
    - rt_prediction_correct = (ex_taken == pred_taken) & (!ex_taken | ex_target == pred_pc).
  - rob_retire_branch while !retire_ready is a stall: no state change and no rt pulse; ROB must hold the request.
- **Mispredict:**
  - When the retired entry's prediction is incorrect, flush=1 alongside rt_en_branch.
  - At the retire edge, all entries are invalidated; head=tail=0 and count=0.
  - A same-cycle allocate or resolve is dropped (flush has priority).
- **Simultaneous events:**
  - Allocate and correct retire in the same cycle: both happen; count unchanged.
  - When full, an allocate is refused even if a retire occurs the same cycle.
- **Idle outputs:** rt_* data fields hold their last values when rt_en_branch=0; only rt_en_branch and flush are pulses.
- **Enable low:** no state change; rt_en_branch=0 and flush=0 on the next cycle.

Test Plan:
1. **Reset:** reset high 1 cycle → count=0, fe_alloc_ready=1 after release, rt_en_branch=0, flush=0, retire_ready=0.
2. **Mispredict:**
   - Stimulus: alloc pc=80, pred_taken=0, pred_pc=84, obq_index=3; resolve tag 0 with taken=1, target=160; retire.
   - Response: next cycle rt_en_branch=1, rt_pc=80, rt_calculated_pc=160, rt_branch_taken=1, rt_prediction_correct=0, rt_branch_index=3, flush=1; count=0.
3. **Correct prediction:** alloc pc=0x20, pred_taken=1, pred_pc=0x30; resolve taken, 0x30; retire → rt_prediction_correct=1, flush=0, rt_calculated_pc=0x30.
4. **Stall and wrong-target:**
   - Stimulus: retire request with head unresolved for 3 cycles.
   - Response: retire_ready=0, no rt pulse, count unchanged.
   - Then resolve taken with target≠pred_pc → rt_prediction_correct=0.
5. **Full and wrap-around:**
   - Stimulus: 8 allocs → count=8, fe_alloc_ready=0, 9th alloc ignored. Resolve all correct, retire 3, alloc 3.
   - Response: fe_alloc_tag returns 0,1,2 (wrap); in-order rt_pc matches alloc order.
6. **Flush drops same-cycle alloc:**
   - Stimulus: alloc in the same cycle as a mispredicted retire, with 2 younger entries queued.
   - Response: count=0 afterwards; younger entries are never retired.
